shift_out_serializer: RTL and testbench

Parallel-in, serial-out stage directly downstream of the variable right-shift register. It accepts the shifted 8-bit word and the shift amount that produced it. It then transmits only the significant bits (8 − shift) on a one-bit stream with a valid/ready handshake, and marks the last bit and frame completion. This converts the shifter's parallel result into a bit stream for the serial link.

---
 rtl/shift_out_serializer_if.sv | 24 ++
 rtl/shift_out_serializer.sv | 67 ++++++
 tb/tb_shift_out_serializer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/shift_out_serializer_if.sv
// Word-in / bit-out handshake bundle between the right shifter, the serializer and the serial sink.
// slave = serializer side, master = the environment that feeds words and sinks bits.
interface shift_out_serializer_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_shift;
    logic       ser_out;
    logic       ser_valid;
    logic       ser_ready;
    logic       ser_last;
    logic       done;
    logic       busy;

    modport slave (
        input  in_valid, in_data, in_shift, ser_ready,
        output in_ready, ser_out, ser_valid, ser_last, done, busy
    );

    modport master (
        output in_valid, in_data, in_shift, ser_ready,
        input  in_ready, ser_out, ser_valid, ser_last, done, busy
    );
endinterface

// File: rtl/shift_out_serializer.sv
// Serializes the significant (8 - shift) bits of a right-shifted word onto a 1-bit
// valid/ready stream, flagging the last bit and pulsing done once the frame is out.
module shift_out_serializer #(
    parameter bit   MSB_FIRST  = 1'b0,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    shift_out_serializer_if.slave       bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0] state_q, state_d;
    logic [7:0] sreg_q,  sreg_d;
    logic [3:0] cnt_q,   cnt_d;
    logic [3:0] frame_len;

    // shift 0 -> 8 bits, shift 7 -> 1 bit; never 0
    assign frame_len = 4'd8 - {1'b0, bus.in_shift};

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    // MSB-first left-aligns bit N-1 so it always leaves from sreg[7]
                    sreg_d  = MSB_FIRST ? (bus.in_data << bus.in_shift) : bus.in_data;
                    cnt_d   = frame_len;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (bus.ser_ready) begin
                    sreg_d = MSB_FIRST ? {sreg_q[6:0], 1'b0} : {1'b0, sreg_q[7:1]};
                    cnt_d  = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            sreg_q  <= 8'd0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // every output decodes registered state only
    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.ser_valid = (state_q == S_SEND);
    assign bus.ser_last  = (state_q == S_SEND) && (cnt_q == 4'd1);
    assign bus.done      = (state_q == S_DONE);
    assign bus.busy      = (state_q == S_SEND) || (state_q == S_DONE);
    assign bus.ser_out   = (state_q == S_SEND) ? (MSB_FIRST ? sreg_q[7] : sreg_q[0]) : IDLE_LEVEL;
endmodule

// File: tb/tb_shift_out_serializer.sv
// Drives identical word stimulus into an LSB-first and an MSB-first serializer; a
// negedge monitor pops hand-written expected bit streams from per-DUT scoreboards.
module tb_shift_out_serializer;
    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic [2:0] in_shift;
    logic       ser_ready;

    int tests = 0;
    int fails = 0;

    exp_t q[2][$];
    logic pend[2];

    shift_out_serializer_if if0 ();
    shift_out_serializer_if if1 ();

    assign if0.in_valid  = in_valid;
    assign if0.in_data   = in_data;
    assign if0.in_shift  = in_shift;
    assign if0.ser_ready = ser_ready;
    assign if1.in_valid  = in_valid;
    assign if1.in_data   = in_data;
    assign if1.in_shift  = in_shift;
    assign if1.ser_ready = ser_ready;

    shift_out_serializer #(.MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(if0.slave));
    shift_out_serializer #(.MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(if1.slave));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: one accepted bit per valid&&ready cycle; done must follow the last bit exactly.
    task automatic mon(input int id, input logic sv, input logic so, input logic sl,
                       input logic dn, input logic idle);
        exp_t e;
        if (dn || pend[id]) chk($sformatf("done_dut%0d", id), dn, pend[id]);
        pend[id] = 1'b0;
        if (!sv) begin
            chk($sformatf("idle_level_dut%0d", id), so, idle);
        end else if (ser_ready) begin
            if (q[id].size() == 0) begin
                chk($sformatf("unexpected_bit_dut%0d", id), 1'b1, 1'b0);
            end else begin
                e = q[id].pop_front();
                chk($sformatf("bit_dut%0d", id), so, e.b);
                chk($sformatf("last_dut%0d", id), sl, e.last);
                pend[id] = e.last;
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            mon(0, if0.ser_valid, if0.ser_out, if0.ser_last, if0.done, 1'b0);
            mon(1, if1.ser_valid, if1.ser_out, if1.ser_last, if1.done, 1'b1);
        end
    end

    task automatic push_str(input int id, input string s, input logic mark_last);
        for (int i = 0; i < s.len(); i++)
            q[id].push_back('{b: (s[i] == "1"), last: (mark_last && i == s.len() - 1)});
    endtask

    // Called at a negedge with the DUTs idle. s0/s1 are the hand-derived bit orders.
    task automatic send(input logic [7:0] d, input logic [2:0] sh, input string s0, input string s1,
                        input int stall_after, input int stall_len,
                        input logic hold, input logic [7:0] nd, input logic [2:0] nsh);
        int n, ready_k, done_k, last_k;
        n = s0.len();
        ready_k = 0; done_k = 0; last_k = 0;
        push_str(0, s0, 1'b1);
        push_str(1, s1, 1'b1);
        in_data  = d;
        in_shift = sh;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        if (hold) begin
            in_data  = nd;
            in_shift = nsh;
        end else begin
            in_valid = 1'b0;
        end
        for (int k = 1; k <= 40; k++) begin
            ser_ready = !(stall_len > 0 && k > stall_after && k <= stall_after + stall_len);
            @(negedge clk);
            if (!ser_ready && q[0].size() > 0 && q[1].size() > 0) begin
                chk("stall_valid0", if0.ser_valid, 1'b1);
                chk("stall_out0",   if0.ser_out,   q[0][0].b);
                chk("stall_last0",  if0.ser_last,  q[0][0].last);
                chk("stall_out1",   if1.ser_out,   q[1][0].b);
            end
            if (last_k == 0 && if0.ser_last) last_k = k;
            if (done_k == 0 && if0.done)     done_k = k;
            if (if0.in_ready) begin
                ready_k = k;
                break;
            end
            @(posedge clk);
            #1;
        end
        ser_ready = 1'b1;
        chki("last_cycle",  last_k,  n + stall_len);
        chki("done_cycle",  done_k,  n + 1 + stall_len);
        chki("ready_cycle", ready_k, n + 2 + stall_len);
        chk("ready_both", if1.in_ready, 1'b1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_in_ready0"}, if0.in_ready, 1'b1);
        chk({tag, "_valid0"},    if0.ser_valid, 1'b0);
        chk({tag, "_done0"},     if0.done, 1'b0);
        chk({tag, "_busy0"},     if0.busy, 1'b0);
        chk({tag, "_last0"},     if0.ser_last, 1'b0);
        chk({tag, "_out0"},      if0.ser_out, 1'b0);
        chk({tag, "_in_ready1"}, if1.in_ready, 1'b1);
        chk({tag, "_busy1"},     if1.busy, 1'b0);
        chk({tag, "_out1"},      if1.ser_out, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        pend[0]   = 1'b0;
        pend[1]   = 1'b0;
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hFF;
        in_shift  = 3'd0;
        ser_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_state("reset");
        reset_n  = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("post_reset_busy",  if0.busy, 1'b0);
        chk("post_reset_valid", if1.ser_valid, 1'b0);

        send(8'hA5, 3'd0, "10100101", "10100101", 0, 0, 1'b0, 8'h00, 3'd0);
        send(8'h13, 3'd3, "11001",    "10011",    0, 0, 1'b0, 8'h00, 3'd0);
        send(8'h01, 3'd7, "1",        "1",        0, 0, 1'b0, 8'h00, 3'd0);
        send(8'h6E, 3'd1, "0111011",  "1101110",  0, 0, 1'b0, 8'h00, 3'd0);
        // backpressure after bit 2, with the next word already offered during the frame
        send(8'hA5, 3'd0, "10100101", "10100101", 2, 3, 1'b1, 8'h3C, 3'd2);
        send(8'h3C, 3'd2, "001111",   "111100",   0, 0, 1'b0, 8'h00, 3'd0);

        // reset after bit 3 of an 8-bit frame: remaining bits and done are dropped
        push_str(0, "101", 1'b0);
        push_str(1, "101", 1'b0);
        in_data  = 8'hA5;
        in_shift = 3'd0;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        ser_ready = 1'b0;
        reset_n   = 1'b0;
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        ser_ready = 1'b1;
        @(negedge clk);
        chk_reset_state("midreset");
        chki("midreset_q0", q[0].size(), 0);
        chki("midreset_q1", q[1].size(), 0);
        send(8'h0F, 3'd4, "1111", "1111", 0, 0, 1'b0, 8'h00, 3'd0);

        repeat (4) @(negedge clk);
        chki("final_q0", q[0].size(), 0);
        chki("final_q1", q[1].size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
